// File: rtl/rf_access_arbiter_if.sv
// Requester-side bundle for one port of the register-file arbiter.
//   valid/ready : request handshake (ready is a combinational grant)
//   write/lock  : beat type and burst-hold request
//   regsel      : register index, wdata: write data
//   rvalid/rdata: read response, one-cycle pulse with data
// master = requester (CPU datapath or debug loader), slave = arbiter.
interface rf_access_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              valid;
  logic              ready;
  logic              write;
  logic              lock;
  logic [ADDR_W-1:0] regsel;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, write, lock, regsel, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, write, lock, regsel, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// Shares the 8x16 register file between port 0 (CPU datapath) and port 1 (debug/host loader).
// At most one RF access issues per cycle. An accepted beat is registered onto the RF control
// outputs at the next edge; reads return on the requesting port two cycles after acceptance.
// Ports:
//   CLK, reset        : clock, synchronous active-high reset
//   p0, p1            : requester bundles (valid/ready handshake, read response)
//   RFwrite, regW,
//   dataW             : RF write enable, write index, write data (registered)
//   regA, regB        : RF read indices (registered, always equal)
//   dataA             : RF read data, registered inside the RF one cycle after regA
module rf_access_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic                CLK,
  input  logic                reset,
  rf_access_arbiter_if.slave  p0,
  rf_access_arbiter_if.slave  p1,
  output logic                RFwrite,
  output logic [ADDR_W-1:0]   regA,
  output logic [ADDR_W-1:0]   regB,
  output logic [ADDR_W-1:0]   regW,
  output logic [DATA_W-1:0]   dataW,
  input  logic [DATA_W-1:0]   dataA
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e            state_q;
  logic              rr_ptr_q;
  logic              rfwrite_q;
  logic [ADDR_W-1:0] rega_q;
  logic [ADDR_W-1:0] regw_q;
  logic [DATA_W-1:0] dataw_q;
  // Read tag pipeline: stage 1 lines up with regA, stage 2 with dataA.
  logic              rd1_vld_q, rd1_port_q;
  logic              rd2_vld_q, rd2_port_q;

  logic              gnt0, gnt1;
  logic              acc;
  logic              sel_port;
  logic              sel_write;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_wdata;

  // Grant: the owner keeps exclusive access during a burst; otherwise arbitrate.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      StOwn0: gnt0 = p0.valid;
      StOwn1: gnt1 = p1.valid;
      default: begin
        if (p0.valid && p1.valid) begin
          if (RR_EN && rr_ptr_q) gnt1 = 1'b1;
          else                   gnt0 = 1'b1;
        end else begin
          gnt0 = p0.valid;
          gnt1 = p1.valid;
        end
      end
    endcase
    // Nothing is accepted while reset is held.
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign acc       = gnt0 | gnt1;
  assign sel_port  = gnt1;
  assign sel_write = gnt1 ? p1.write  : p0.write;
  assign sel_lock  = gnt1 ? p1.lock   : p0.lock;
  assign sel_reg   = gnt1 ? p1.regsel : p0.regsel;
  assign sel_wdata = gnt1 ? p1.wdata  : p0.wdata;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 1'b0;
      rfwrite_q  <= 1'b0;
      rega_q     <= '0;
      regw_q     <= '0;
      dataw_q    <= '0;
      rd1_vld_q  <= 1'b0;
      rd1_port_q <= 1'b0;
      rd2_vld_q  <= 1'b0;
      rd2_port_q <= 1'b0;
    end else begin
      rfwrite_q <= acc & sel_write;
      if (acc) begin
        rr_ptr_q <= ~sel_port;
        if (sel_write) begin
          regw_q  <= sel_reg;
          dataw_q <= sel_wdata;
        end else begin
          rega_q  <= sel_reg;
        end
      end
      rd1_vld_q  <= acc & ~sel_write;
      rd1_port_q <= sel_port;
      rd2_vld_q  <= rd1_vld_q;
      rd2_port_q <= rd1_port_q;

      unique case (state_q)
        StOwn0: if (!p0.valid || !p0.lock) state_q <= StIdle;
        StOwn1: if (!p1.valid || !p1.lock) state_q <= StIdle;
        default: begin
          if (acc && sel_lock) state_q <= sel_port ? StOwn1 : StOwn0;
          else                 state_q <= StIdle;
        end
      endcase
    end
  end

  assign p0.ready  = gnt0;
  assign p1.ready  = gnt1;
  assign p0.rvalid = rd2_vld_q & ~rd2_port_q;
  assign p1.rvalid = rd2_vld_q &  rd2_port_q;
  assign p0.rdata  = (rd2_vld_q && !rd2_port_q) ? dataA : '0;
  assign p1.rdata  = (rd2_vld_q &&  rd2_port_q) ? dataA : '0;

  assign RFwrite = rfwrite_q;
  assign regA    = rega_q;
  assign regB    = rega_q;
  assign regW    = regw_q;
  assign dataW   = dataw_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
module tb_rf_access_arbiter;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  rf_access_arbiter_if #(.DATA_W(16), .ADDR_W(3)) a0 ();
  rf_access_arbiter_if #(.DATA_W(16), .ADDR_W(3)) a1 ();
  rf_access_arbiter_if #(.DATA_W(16), .ADDR_W(3)) b0 ();
  rf_access_arbiter_if #(.DATA_W(16), .ADDR_W(3)) b1 ();

  logic        rfw_a, rfw_b;
  logic [2:0]  rega_a, regb_a, regw_a, rega_b, regb_b, regw_b;
  logic [15:0] dataw_a, dataa_a, dataw_b, dataa_b;

  // Round-robin instance: fully checked against the reference model.
  rf_access_arbiter #(.DATA_W(16), .ADDR_W(3), .RR_EN(1'b1)) dut_rr (
    .CLK(CLK), .reset(reset), .p0(a0), .p1(a1), .RFwrite(rfw_a), .regA(rega_a),
    .regB(regb_a), .regW(regw_a), .dataW(dataw_a), .dataA(dataa_a)
  );

  // Fixed-priority instance: only its grants are checked.
  rf_access_arbiter #(.DATA_W(16), .ADDR_W(3), .RR_EN(1'b0)) dut_fp (
    .CLK(CLK), .reset(reset), .p0(b0), .p1(b1), .RFwrite(rfw_b), .regA(rega_b),
    .regB(regb_b), .regW(regw_b), .dataW(dataw_b), .dataA(dataa_b)
  );
  assign dataa_b = '0;

  // Register file attached to the round-robin instance.
  logic [15:0] rf_a [8] = '{default: '0};
  always @(posedge CLK) begin
    if (rfw_a) rf_a[regw_a] <= dataw_a;
    dataa_a <= rf_a[rega_a];
  end

  // ---------------- reference model ----------------
  typedef struct { int due; int port; logic [15:0] data; } rsp_t;
  rsp_t        rsp_q[$];
  logic [15:0] mdl_mem [8];
  int          mdl_own;   // -1 none, else owning port
  int          mdl_rr;    // port favoured when both are valid
  int          cyc;
  int          wr_due, rd_due;
  logic [2:0]  wr_reg, rd_reg;
  logic [15:0] wr_data;

  int n_vec, n_bad;

  logic        exp_rdy0, exp_rdy1, exp_rfw, exp_rv0, exp_rv1, chk_rd;
  logic [2:0]  exp_regw, exp_rega;
  logic [15:0] exp_dataw, exp_rd0, exp_rd1;
  logic        obs_rdy0, obs_rdy1, obs_rfw, obs_rv0, obs_rv1, obs_fp0, obs_fp1;
  logic [2:0]  obs_regw, obs_rega, obs_regb;
  logic [15:0] obs_dataw, obs_rd0, obs_rd1;

  function automatic int model_grant(int own, int rr, logic v0, logic v1);
    if (own == 0) return v0 ? 0 : -1;
    if (own == 1) return v1 ? 1 : -1;
    if (v0 && v1) return rr;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic drive(input int p, input bit v, input bit w, input bit l, input int r,
                       input int d);
    if (p == 0) begin
      a0.valid = v; a0.write = w; a0.lock = l; a0.regsel = 3'(r); a0.wdata = 16'(d);
    end else begin
      a1.valid = v; a1.write = w; a1.lock = l; a1.regsel = 3'(r); a1.wdata = 16'(d);
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // One clock cycle: compute expectations, snapshot outputs, advance the model.
  task automatic step();
    int g;
    bit gw, gl;
    logic [2:0] gr;
    logic [15:0] gd;
    #1;
    g = reset ? -1 : model_grant(mdl_own, mdl_rr, a0.valid, a1.valid);
    exp_rdy0 = (g == 0);
    exp_rdy1 = (g == 1);
    exp_rfw = (wr_due == cyc); exp_regw = wr_reg; exp_dataw = wr_data;
    chk_rd = (rd_due == cyc); exp_rega = rd_reg;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      if (rsp_q[0].port == 0) begin exp_rv0 = 1'b1; exp_rd0 = rsp_q[0].data; end
      else begin exp_rv1 = 1'b1; exp_rd1 = rsp_q[0].data; end
      void'(rsp_q.pop_front());
    end
    obs_rdy0 = a0.ready; obs_rdy1 = a1.ready; obs_rv0 = a0.rvalid; obs_rv1 = a1.rvalid;
    obs_rd0 = a0.rdata; obs_rd1 = a1.rdata; obs_rfw = rfw_a; obs_rega = rega_a;
    obs_regb = regb_a; obs_regw = regw_a; obs_dataw = dataw_a;
    obs_fp0 = b0.ready; obs_fp1 = b1.ready;
    gw = 1'b0; gl = 1'b0; gr = '0; gd = '0;
    if (g == 0) begin gw = a0.write; gl = a0.lock; gr = a0.regsel; gd = a0.wdata; end
    if (g == 1) begin gw = a1.write; gl = a1.lock; gr = a1.regsel; gd = a1.wdata; end
    @(posedge CLK);
    if (reset) begin
      mdl_own = -1; mdl_rr = 0; rsp_q.delete(); wr_due = -1; rd_due = -1;
    end else begin
      if (g >= 0) begin
        mdl_rr = 1 - g;
        if (gw) begin
          mdl_mem[gr] = gd; wr_due = cyc + 1; wr_reg = gr; wr_data = gd;
        end else begin
          rsp_q.push_back('{due: cyc + 2, port: g, data: mdl_mem[gr]});
          rd_due = cyc + 1; rd_reg = gr;
        end
      end
      mdl_own = (g >= 0 && gl) ? g : -1;
    end
    cyc++;
    @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; idle(); step();
    a0.valid = 1'b1; a1.valid = 1'b1;  // grants must stay low while reset is held
    step();
    n_vec++; if (obs_rdy0 !== 1'b0) begin n_bad++; $display("FAIL reset.rdy0 got %0b want 0", obs_rdy0); end
    n_vec++; if (obs_rdy1 !== 1'b0) begin n_bad++; $display("FAIL reset.rdy1 got %0b want 0", obs_rdy1); end
    n_vec++; if (obs_rfw !== 1'b0) begin n_bad++; $display("FAIL reset.RFwrite got %0b want 0", obs_rfw); end
    n_vec++; if (obs_rega !== 3'd0) begin n_bad++; $display("FAIL reset.regA got %0d want 0", obs_rega); end
    n_vec++; if (obs_regb !== 3'd0) begin n_bad++; $display("FAIL reset.regB got %0d want 0", obs_regb); end
    n_vec++; if (obs_regw !== 3'd0) begin n_bad++; $display("FAIL reset.regW got %0d want 0", obs_regw); end
    n_vec++; if (obs_dataw !== 16'h0) begin n_bad++; $display("FAIL reset.dataW got %0h want 0", obs_dataw); end
    n_vec++; if (obs_rv0 !== 1'b0 || obs_rv1 !== 1'b0) begin
      n_bad++; $display("FAIL reset.rvalid got %0b%0b want 00", obs_rv1, obs_rv0);
    end
    n_vec++; if (obs_rd0 !== 16'h0 || obs_rd1 !== 16'h0) begin
      n_bad++; $display("FAIL reset.rdata got %0h/%0h want 0/0", obs_rd0, obs_rd1);
    end
    reset = 1'b0; idle(); step();
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 1'b1, 1'b0, 3, 'hBEEF); step();
    n_vec++; if (obs_rdy0 !== 1'b1) begin n_bad++; $display("FAIL wr_rd.rdy0 got %0b want 1", obs_rdy0); end
    drive(0, 1'b1, 1'b0, 1'b0, 3, 0); step();
    n_vec++; if (obs_rfw !== 1'b1) begin n_bad++; $display("FAIL wr_rd.RFwrite got %0b want 1", obs_rfw); end
    n_vec++; if (obs_regw !== 3'd3) begin n_bad++; $display("FAIL wr_rd.regW got %0d want 3", obs_regw); end
    n_vec++; if (obs_dataw !== 16'hBEEF) begin n_bad++; $display("FAIL wr_rd.dataW got %0h want beef", obs_dataw); end
    idle(); step();
    n_vec++; if (obs_rfw !== 1'b0) begin n_bad++; $display("FAIL wr_rd.RFwrite_pulse got %0b want 0", obs_rfw); end
    n_vec++; if (obs_rega !== 3'd3 || obs_regb !== 3'd3) begin
      n_bad++; $display("FAIL wr_rd.regAB got %0d/%0d want 3/3", obs_rega, obs_regb);
    end
    n_vec++; if (obs_rv0 !== 1'b0) begin n_bad++; $display("FAIL wr_rd.early_rvalid got %0b want 0", obs_rv0); end
    step();
    n_vec++; if (obs_rv0 !== 1'b1) begin n_bad++; $display("FAIL wr_rd.rvalid got %0b want 1", obs_rv0); end
    n_vec++; if (obs_rd0 !== 16'hBEEF) begin n_bad++; $display("FAIL wr_rd.rdata got %0h want beef", obs_rd0); end
    n_vec++; if (obs_rv1 !== 1'b0) begin n_bad++; $display("FAIL wr_rd.p1_rvalid got %0b want 0", obs_rv1); end
    step();
    n_vec++; if (obs_rv0 !== 1'b0) begin n_bad++; $display("FAIL wr_rd.rvalid_pulse got %0b want 0", obs_rv0); end
  endtask

  task automatic test_rr_alternate();
    logic e0, e1;
    drive(0, 1'b1, 1'b1, 1'b0, 1, 'h1111); step();
    drive(0, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b1, 1'b1, 1'b0, 2, 'h2222); step();  // last grant to p1 -> p0 favoured next
    for (int i = 0; i < 10; i++) begin
      drive(0, i < 8, 1'b0, 1'b0, 1, 0);
      drive(1, i < 8, 1'b0, 1'b0, 2, 0);
      step();
      e0 = (i < 8) && (i % 2 == 0);
      e1 = (i < 8) && (i % 2 == 1);
      n_vec++; if (obs_rdy0 !== e0 || obs_rdy1 !== e1) begin
        n_bad++; $display("FAIL rr.grant[%0d] got %0b%0b want %0b%0b", i, obs_rdy1, obs_rdy0, e1, e0);
      end
      if (i >= 2) begin
        e0 = (i % 2 == 0);
        n_vec++; if (obs_rv0 !== e0 || obs_rv1 !== !e0) begin
          n_bad++; $display("FAIL rr.rvalid[%0d] got %0b%0b want %0b%0b", i, obs_rv1, obs_rv0, !e0, e0);
        end
        n_vec++; if (e0 ? (obs_rd0 !== 16'h1111) : (obs_rd1 !== 16'h2222)) begin
          n_bad++; $display("FAIL rr.rdata[%0d] got %0h/%0h", i, obs_rd0, obs_rd1);
        end
      end
    end
  endtask

  task automatic test_fixed_priority();
    b0.write = 1'b0; b0.lock = 1'b0; b0.regsel = 3'd0; b0.wdata = '0; b0.valid = 1'b1;
    b1.write = 1'b0; b1.lock = 1'b0; b1.regsel = 3'd1; b1.wdata = '0; b1.valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) b0.valid = 1'b0;
      step();
      n_vec++; if (obs_fp0 !== (i < 4) || obs_fp1 !== (i >= 4)) begin
        n_bad++; $display("FAIL fixed.grant[%0d] got %0b%0b want %0b%0b", i, obs_fp1, obs_fp0, i >= 4, i < 4);
      end
    end
    b1.valid = 1'b0; step();
  endtask

  task automatic test_lock();
    logic ew;
    drive(0, 1'b1, 1'b0, 1'b0, 7, 0); step();  // p0 beat alone -> p1 favoured next
    n_vec++; if (obs_rdy0 !== 1'b1) begin n_bad++; $display("FAIL lock.pre_rdy0 got %0b want 1", obs_rdy0); end
    for (int i = 0; i < 6; i++) begin
      drive(0, i < 5, 1'b0, 1'b0, 7, 0);
      if (i < 4) drive(1, 1'b1, 1'b1, i < 3, i, 'hA000 + i);
      else       drive(1, 1'b1, 1'b1, 1'b0, 4, 'hA004);
      step();
      n_vec++; if (obs_rdy1 !== (i < 4 || i == 5) || obs_rdy0 !== (i == 4)) begin
        n_bad++; $display("FAIL lock.grant[%0d] got %0b%0b", i, obs_rdy1, obs_rdy0);
      end
      ew = (i >= 1 && i <= 4);
      n_vec++; if (obs_rfw !== ew) begin
        n_bad++; $display("FAIL lock.RFwrite[%0d] got %0b want %0b", i, obs_rfw, ew);
      end
      if (ew) begin
        n_vec++; if (obs_regw !== 3'(i - 1) || obs_dataw !== 16'(32'hA000 + i - 1)) begin
          n_bad++; $display("FAIL lock.wbeat[%0d] got r%0d=%0h", i, obs_regw, obs_dataw);
        end
      end
    end
    idle(); step(); step(); step();
  endtask

  task automatic test_ordering();
    drive(1, 1'b1, 1'b1, 1'b0, 5, 'h1234); step();
    n_vec++; if (obs_rdy1 !== 1'b1) begin n_bad++; $display("FAIL order.rdy1 got %0b want 1", obs_rdy1); end
    drive(1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(0, 1'b1, 1'b0, 1'b0, 5, 0); step();
    n_vec++; if (obs_rdy0 !== 1'b1) begin n_bad++; $display("FAIL order.rdy0 got %0b want 1", obs_rdy0); end
    idle(); step(); step();
    n_vec++; if (obs_rv0 !== 1'b1 || obs_rd0 !== 16'h1234) begin
      n_bad++; $display("FAIL order.rdata got v=%0b %0h want v=1 1234", obs_rv0, obs_rd0);
    end
  endtask

  task automatic test_reset_inflight();
    drive(0, 1'b1, 1'b0, 1'b0, 1, 0); step();
    drive(0, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b1, 1'b0, 1'b1, 2, 0); step();  // locked beat: p1 owns the RF
    idle(); reset = 1'b1; step();
    n_vec++; if (obs_rv0 !== 1'b1 || obs_rd0 !== exp_rd0) begin
      n_bad++; $display("FAIL rst_fly.last_rvalid got v=%0b %0h want v=1 %0h", obs_rv0, obs_rd0, exp_rd0);
    end
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b1, 1'b0, 1'b0, 0, 0); step();
    n_vec++; if (obs_rdy0 !== 1'b1 || obs_rdy1 !== 1'b0) begin
      n_bad++; $display("FAIL rst_fly.state_idle got %0b%0b want 01", obs_rdy1, obs_rdy0);
    end
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (obs_rv0 !== 1'b0 || obs_rv1 !== 1'b0 || obs_rfw !== 1'b0) begin
        n_bad++; $display("FAIL rst_fly.quiet[%0d] got rv=%0b%0b w=%0b want 000", i, obs_rv1, obs_rv0, obs_rfw);
      end
      idle(); step();
    end
    step();
    // Leave the pointer at p1, then check reset brings it back to p0.
    drive(0, 1'b1, 1'b0, 1'b0, 0, 0); step();
    idle(); reset = 1'b1; step();
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b1, 1'b0, 1'b0, 0, 0); step();
    n_vec++; if (obs_rdy0 !== 1'b1 || obs_rdy1 !== 1'b0) begin
      n_bad++; $display("FAIL rst_fly.rr_ptr got %0b%0b want 01", obs_rdy1, obs_rdy0);
    end
    idle(); step(); step(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(63) == 0);
      for (int p = 0; p < 2; p++)
        drive(p, $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
              int'($urandom_range(7)), int'($urandom_range(16'hFFFF)));
      step();
      n_vec++; if (obs_rdy0 !== exp_rdy0 || obs_rdy1 !== exp_rdy1) begin
        n_bad++; $display("FAIL rand.grant[%0d] got %0b%0b want %0b%0b", i, obs_rdy1, obs_rdy0, exp_rdy1, exp_rdy0);
      end
      n_vec++; if (obs_rfw !== exp_rfw) begin
        n_bad++; $display("FAIL rand.RFwrite[%0d] got %0b want %0b", i, obs_rfw, exp_rfw);
      end
      if (exp_rfw) begin
        n_vec++; if (obs_regw !== exp_regw || obs_dataw !== exp_dataw) begin
          n_bad++; $display("FAIL rand.wbeat[%0d] got r%0d=%0h want r%0d=%0h", i, obs_regw, obs_dataw, exp_regw, exp_dataw);
        end
      end
      if (chk_rd) begin
        n_vec++; if (obs_rega !== exp_rega || obs_regb !== exp_rega) begin
          n_bad++; $display("FAIL rand.regAB[%0d] got %0d/%0d want %0d", i, obs_rega, obs_regb, exp_rega);
        end
      end
      n_vec++; if (obs_rv0 !== exp_rv0 || obs_rv1 !== exp_rv1) begin
        n_bad++; $display("FAIL rand.rvalid[%0d] got %0b%0b want %0b%0b", i, obs_rv1, obs_rv0, exp_rv1, exp_rv0);
      end
      if (exp_rv0) begin
        n_vec++; if (obs_rd0 !== exp_rd0) begin
          n_bad++; $display("FAIL rand.rdata0[%0d] got %0h want %0h", i, obs_rd0, exp_rd0);
        end
      end
      if (exp_rv1) begin
        n_vec++; if (obs_rd1 !== exp_rd1) begin
          n_bad++; $display("FAIL rand.rdata1[%0d] got %0h want %0h", i, obs_rd1, exp_rd1);
        end
      end
    end
    reset = 1'b0; idle(); step(); step(); step();
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    mdl_own = -1; mdl_rr = 0; wr_due = -1; rd_due = -1;
    wr_reg = '0; rd_reg = '0; wr_data = '0;
    for (int i = 0; i < 8; i++) mdl_mem[i] = '0;
    idle();
    b0.valid = 1'b0; b0.write = 1'b0; b0.lock = 1'b0; b0.regsel = '0; b0.wdata = '0;
    b1.valid = 1'b0; b1.write = 1'b0; b1.lock = 1'b0; b1.regsel = '0; b1.wdata = '0;
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_rr_alternate();
    test_fixed_priority();
    test_lock();
    test_ordering();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
